rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 2**width-way select resource between 2**width requesters. It registers a binary grant index, expands it to a one-hot grant vector with the same shift-decode used by the team's 3-to-8 decoder, and holds each grant until the owner releases it or a hold-timeout forces a release. The block sits in front of any shared datapath that takes a one-hot select, such as a mux or bus owner enable.

---
 rtl/rr_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registers a binary grant index, decodes it to a one-hot
// grant, and holds each grant until done, owner request drop, or hold timeout.
module rr_arbiter #(
  parameter int width    = 3,
  parameter int max_hold = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [(2**width)-1:0]   req,
  input  logic                    done,
  output logic [(2**width)-1:0]   gnt,
  output logic [width-1:0]        gnt_idx,
  output logic                    gnt_vld,
  output logic                    preempt
);

  localparam int N     = 2**width;
  localparam int CNT_W = (max_hold > 1) ? $clog2(max_hold) : 1;
  localparam bit TO_EN = (max_hold != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((max_hold > 0) ? max_hold - 1 : 0);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [width-1:0] ptr_q,      ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [width-1:0] gnt_idx_q,  gnt_idx_d;
  logic             gnt_vld_q,  gnt_vld_d;
  logic             preempt_q,  preempt_d;

  logic             pick_found;
  logic [width-1:0] pick_idx;
  logic [width-1:0] cand;
  logic             rel_done;
  logic             rel_drop;
  logic             rel_timeout;
  logic             release_now;

  // Search starts at ptr and wraps; the width-bit addition provides the modulo.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 0; off < N; off++) begin
      cand = ptr_q + width'(off);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    rel_done    = done;
    rel_drop    = !req[gnt_idx_q];
    rel_timeout = TO_EN && (hold_cnt_q == HOLD_LAST);
    release_now = rel_done || rel_drop || rel_timeout;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    preempt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_idx;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = IDLE;
          gnt_idx_d  = '0;
          gnt_vld_d  = 1'b0;
          hold_cnt_d = '0;
          ptr_d      = gnt_idx_q + width'(1);
          // Timeout only counts as preemption when nothing else ended the grant.
          preempt_d  = rel_timeout && !rel_done && !rel_drop;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      preempt_q  <= preempt_d;
    end
  end

  // One-hot shift-decode of the registered index; never depends on req directly.
  assign gnt     = gnt_vld_q ? (N'(1) << gnt_idx_q) : '0;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance with the default hold limit and
// one with max_hold = 4 for the timeout behaviour.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic       done_a, done_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] gnt_idx_a, gnt_idx_b;
  logic       gnt_vld_a, gnt_vld_b;
  logic       preempt_a, preempt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.width(3), .max_hold(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_idx(gnt_idx_a), .gnt_vld(gnt_vld_a), .preempt(preempt_a)
  );

  rr_arbiter #(.width(3), .max_hold(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_vld(gnt_vld_b), .preempt(preempt_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic vld, input logic pre);
    check({tag, ".gnt"},     32'(gnt_a),     32'(g));
    check({tag, ".gnt_idx"}, 32'(gnt_idx_a), 32'(idx));
    check({tag, ".gnt_vld"}, 32'(gnt_vld_a), 32'(vld));
    check({tag, ".preempt"}, 32'(preempt_a), 32'(pre));
  endtask

  task automatic check_b(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic vld, input logic pre);
    check({tag, ".gnt"},     32'(gnt_b),     32'(g));
    check({tag, ".gnt_idx"}, 32'(gnt_idx_b), 32'(idx));
    check({tag, ".gnt_vld"}, 32'(gnt_vld_b), 32'(vld));
    check({tag, ".preempt"}, 32'(preempt_b), 32'(pre));
  endtask

  initial begin
    rst_n  = 1'b0;
    req_a  = '0;
    req_b  = '0;
    done_a = 1'b0;
    done_b = 1'b0;
    tick();
    tick();
    check_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    check_b("reset_b", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // done while idle is ignored
    done_a = 1'b1;
    tick();
    check_a("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);
    done_a = 1'b0;

    // single request, then release by done (ptr becomes 3)
    req_a = 8'b0000_0100;
    tick();
    check_a("single", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
    done_a = 1'b1;
    tick();
    check_a("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done_a = 1'b0;

    // pointer at 3: search wraps past 7 to find 0 before 2
    req_a = 8'b0000_0101;
    tick();
    check_a("ptr_wrap", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
    done_a = 1'b1;
    tick();
    check_a("ptr_wrap_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    done_a = 1'b0;
    req_a  = '0;

    // reset restores ptr 0 for the rotation run
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // rotation with all requesters active: 0..7 then back to 0
    req_a = 8'hFF;
    for (int e = 0; e < 9; e++) begin
      tick();
      check_a($sformatf("rot%0d", e), 8'(1 << (e % 8)), 3'(e % 8), 1'b1, 1'b0);
      tick();
      check("rot_hold", 32'(gnt_vld_a), 32'd1);
      done_a = 1'b1;
      tick();
      check_a($sformatf("rot%0d_rel", e), 8'h00, 3'd0, 1'b0, 1'b0);
      done_a = 1'b0;
    end

    // owner drop: ptr is 1, requesters 5 and 6 active, 5 wins then drops
    req_a = 8'h60;
    tick();
    check_a("own5", 8'h20, 3'd5, 1'b1, 1'b0);
    tick();
    check_a("own5_hold", 8'h20, 3'd5, 1'b1, 1'b0);
    req_a = 8'h40;
    tick();
    check_a("own5_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_a("own6", 8'h40, 3'd6, 1'b1, 1'b0);

    // asynchronous reset mid-grant clears outputs before the next edge
    tick();
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    req_a = 8'hC0;
    #2;
    rst_n = 1'b1;
    tick();
    check_a("post_rst", 8'h40, 3'd6, 1'b1, 1'b0);
    req_a = '0;

    // timeout on dut_b: idx 0 held exactly 4 cycles, then preempt pulse
    req_b = 8'b0000_0011;
    tick();
    check_b("to_g0", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      tick();
      check_b($sformatf("to_g0_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    check_b("to_rel0", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    check_b("to_g1", 8'h02, 3'd1, 1'b1, 1'b0);
    for (int c = 1; c < 4; c++) begin
      tick();
      check_b($sformatf("to_g1_c%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    // done on the timeout cycle suppresses preempt
    done_b = 1'b1;
    tick();
    check_b("to_rel1_done", 8'h00, 3'd0, 1'b0, 1'b0);
    done_b = 1'b0;
    req_b  = '0;
    tick();
    check_b("to_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
